// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/bubble sequencer for the 5-stage IF/ID/EX/M/WB pipeline.
//
// Freezes PC and IF/ID and drops a NOOP bubble into ID/EX for one cycle on a
// load-use hazard between ID and EX. Also hands the register file and data
// memory to a host: it drains the pipeline, grants the host, then resumes fetch.
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   rs_ID, rt_ID               source registers of the ID instruction
//   use_rs_ID, use_rt_ID       ID instruction actually reads rs / rt
//   LW_EX, WRE_EX, rt_EX       EX instruction is a load / writes RF / destination
//   host_req, host_done        host access request (level), end-of-access pulse
//   pc_we, ifid_we             PC and IF/ID write enables
//   idex_bubble                force a NOOP into ID/EX
//   host_gnt                   host owns RF/DMEM (registered)
//   state                      RUN=0, DRAIN=1, HOST=2, RESUME=3
//   stall_cnt                  saturating count of load-use stall cycles
module pipe_stall_ctrl #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_ID,
    input  logic [REG_ADDR_W-1:0] rt_ID,
    input  logic                  use_rs_ID,
    input  logic                  use_rt_ID,
    input  logic                  LW_EX,
    input  logic                  WRE_EX,
    input  logic [REG_ADDR_W-1:0] rt_EX,
    input  logic                  host_req,
    input  logic                  host_done,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  idex_bubble,
    output logic                  host_gnt,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StDrain  = 2'd1;
    localparam logic [1:0] StHost   = 2'd2;
    localparam logic [1:0] StResume = 2'd3;

    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              hz;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign hz = LW_EX & WRE_EX & (rt_EX != '0) &
                ((use_rs_ID & (rs_ID == rt_EX)) | (use_rt_ID & (rt_ID == rt_EX)));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;

        case (state_q)
            StRun: begin
                // Host wins over a same-cycle hazard; the held ID instruction
                // is reissued after RESUME.
                if (host_req) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                end else if (hz) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    idex_bubble = 1'b0;
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StHost;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StHost: begin
                if (host_done) begin
                    state_d = StResume;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        gnt_d = (state_d == StHost);

        if (!rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            drain_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign host_gnt  = gnt_q;
    assign state     = state_q;
    assign stall_cnt = cnt_q;

endmodule
